eight_bit_ripple_adder: RTL and testbench
=========================================

Name: eight_bit_ripple_adder

Overview:
- Registered 8-bit binary adder: a + b + cin, giving an 8-bit sum and a carry-out.
- Datapath is structural: a chain of identical 1-bit full-adder cells with the carry rippling from bit 0 to the MSB.
- Result is captured in an output register on the single clock.
- Used as a generic arithmetic leaf wherever a registered add with carry-in/carry-out is needed.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 1; the chain has exactly WIDTH full-adder cells.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered sum bits [WIDTH-1:0].
- cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Full-adder cell i computes:
  - s_i = a[i] ^ b[i] ^ c_i
  - c_(i+1) = (a[i] & b[i]) | (c_i & (a[i] ^ b[i]))
  - c_0 = cin; cout_comb = c_WIDTH.
- The cell is a separate submodule, instantiated WIDTH times (generate loop or explicit instances).
  - Do not use a behavioural "+" for the datapath.
- Arithmetic: {cout_comb, sum_comb} = a + b + cin, exact, no saturation.
  - Result range 0 .. 2^(WIDTH+1)-1; overflow shows only as cout = 1.
- Output register on every rising clk edge:
  - if rst = 1: sum <= 0, cout <= 0.
  - else: sum <= sum_comb, cout <= cout_comb.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on sum/cout after edge N.
  - No enable and no handshake; a new operation is accepted every cycle (throughput 1/cycle).
- Reset:
  - Synchronous only. Asserting rst between edges changes nothing until the next rising edge.
  - rst has priority over data at that edge.
  - The first edge after rst deasserts loads the current inputs.
- Outputs are purely registered, with no combinational path from inputs to outputs.
- Power-up before the first reset edge is undefined.
- Wrap-around: carry out of the MSB goes only to cout. It never wraps into bit 0 and is never fed back.
- Inputs are assumed stable around the clock edge. X on any input may produce X on outputs; no X-filtering is required.
- The critical path is the full ripple chain (WIDTH cells) and must close within one clk period.

Test Plan:
- Reset: hold rst = 1 with a = 8'hFF, b = 8'hFF, cin = 1 for 2 edges -> sum = 8'h00, cout = 0. Deassert rst -> next edge sum = 8'hFF, cout = 1.
- Basic adds, one per cycle, with cin = 0; each checked one cycle after application:
  - 0 + 0 -> 8'h00, cout 0
  - 8'h01 + 8'h02 -> 8'h03, cout 0
  - 8'h04 + 8'h02 -> 8'h06, cout 0
  - 8'hA0 + 8'h05 -> 8'hA5, cout 0
- Carry propagation, cin = 0:
  - 8'h0F + 8'hF0 -> 8'hFF, cout 0
  - 8'h18 + 8'hDB -> 8'hF3, cout 0
  - 8'h66 + 8'h26 -> 8'h8C, cout 0
- Carry-in and full ripple:
  - 8'h6E + 8'h66 + cin 1 -> 8'hD5, cout 0
  - 8'hFF + 8'hFF + cin 1 -> 8'hFF, cout 1
  - 8'hFF + 8'h00 + cin 1 -> 8'h00, cout 1 (carry through all 8 cells)
- Back-to-back pipelining: change inputs every cycle with random vectors -> each output equals the reference a + b + cin of the previous cycle's inputs; no stalls or dropped results.
- Mid-stream reset: assert rst for one edge during the random stream -> that cycle's output is 0/0; the following cycle resumes correct results from the inputs present at that edge.

Source files
------------

// File: rtl/eight_bit_ripple_adder.sv
// eight_bit_ripple_adder
//   Registered WIDTH-bit adder: {cout, sum} <= a + b + cin, one cycle latency,
//   one new operation accepted every cycle. The datapath is a structural chain
//   of full-adder cells with the carry rippling from bit 0 up to the MSB; no
//   behavioural '+' is used.
//
//   Ports
//     clk   in   1      rising-edge clock
//     rst   in   1      synchronous active-high reset (clears sum/cout)
//     a     in   WIDTH  operand A, unsigned
//     b     in   WIDTH  operand B, unsigned
//     cin   in   1      carry into bit 0
//     sum   out  WIDTH  registered sum
//     cout  out  1      registered carry out of bit WIDTH-1

// One bit of the chain. Kept as its own module so the netlist shows exactly
// WIDTH identical cells and the ripple path is easy to trace in timing reports.
//   a, b, ci : operand bits and incoming carry
//   s, co    : sum bit and outgoing carry
module ripple_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  // Propagate term is shared between the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module eight_bit_ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("eight_bit_ripple_adder: WIDTH must be >= 1");
    end
  endgenerate

  // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB and only
  // ever lands in cout, never back into bit 0.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      ripple_fa_cell u_cell (
        .a  (a[i]),
        .b  (b[i]),
        .ci (carry[i]),
        .s  (sum_comb[i]),
        .co (carry[i+1])
      );
    end
  endgenerate

  // Output register: the only path from inputs to outputs goes through here,
  // so downstream logic sees a clean flop and the ripple chain owns the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_comb;
      cout <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_eight_bit_ripple_adder.sv
module tb_eight_bit_ripple_adder;
  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int errors;

  eight_bit_ripple_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are changed 1 time unit after a rising edge; outputs are sampled
  // at that same point, i.e. well away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (sum !== 8'h00 || cout !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold%0d got sum=%h cout=%b want sum=00 cout=0", k, sum, cout);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (sum !== 8'hFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got sum=%h cout=%b want sum=ff cout=1", sum, cout);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va [4] = '{8'h00, 8'h01, 8'h04, 8'hA0};
    logic [7:0] vb [4] = '{8'h00, 8'h02, 8'h02, 8'h05};
    logic [7:0] vs [4] = '{8'h00, 8'h03, 8'h06, 8'hA5};
    for (int k = 0; k < 4; k++) begin
      a = va[k]; b = vb[k]; cin = 1'b0;
      step();
      checks++;
      if (sum !== vs[k] || cout !== 1'b0) begin
        errors++;
        $display("FAIL basic%0d got sum=%h cout=%b want sum=%h cout=0", k, sum, cout, vs[k]);
      end
    end
  endtask

  task automatic test_carry_prop();
    logic [7:0] va [3] = '{8'h0F, 8'h18, 8'h66};
    logic [7:0] vb [3] = '{8'hF0, 8'hDB, 8'h26};
    logic [7:0] vs [3] = '{8'hFF, 8'hF3, 8'h8C};
    for (int k = 0; k < 3; k++) begin
      a = va[k]; b = vb[k]; cin = 1'b0;
      step();
      checks++;
      if (sum !== vs[k] || cout !== 1'b0) begin
        errors++;
        $display("FAIL carry%0d got sum=%h cout=%b want sum=%h cout=0", k, sum, cout, vs[k]);
      end
    end
  endtask

  task automatic test_cin_ripple();
    logic [7:0] va [3] = '{8'h6E, 8'hFF, 8'hFF};
    logic [7:0] vb [3] = '{8'h66, 8'hFF, 8'h00};
    logic [7:0] vs [3] = '{8'hD5, 8'hFF, 8'h00};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      a = va[k]; b = vb[k]; cin = 1'b1;
      step();
      checks++;
      if (sum !== vs[k] || cout !== vc[k]) begin
        errors++;
        $display("FAIL cin%0d got sum=%h cout=%b want sum=%h cout=%b", k, sum, cout, vs[k], vc[k]);
      end
    end
  endtask

  // Output must hold between edges even if inputs and rst move.
  task automatic test_registered();
    a = 8'h10; b = 8'h20; cin = 1'b0;
    step();
    a = 8'hFF; b = 8'h01; cin = 1'b1; rst = 1'b1;
    #3;
    checks++;
    if (sum !== 8'h30 || cout !== 1'b0) begin
      errors++;
      $display("FAIL registered_hold got sum=%h cout=%b want sum=30 cout=0", sum, cout);
    end
    rst = 1'b0;
    step();
    checks++;
    if (sum !== 8'h01 || cout !== 1'b1) begin
      errors++;
      $display("FAIL registered_next got sum=%h cout=%b want sum=01 cout=1", sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [8] = '{8'h3C, 8'h80, 8'h7F, 8'h55, 8'h12, 8'hFE, 8'h99, 8'hC8};
    logic [7:0] vb [8] = '{8'hC3, 8'h80, 8'h01, 8'hAA, 8'h34, 8'h01, 8'h66, 8'h64};
    logic       vi [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] vs [8] = '{8'hFF, 8'h00, 8'h80, 8'h00, 8'h47, 8'h00, 8'hFF, 8'h2C};
    logic       vc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      a = va[k]; b = vb[k]; cin = vi[k];
      step();
      checks++;
      if (sum !== vs[k] || cout !== vc[k]) begin
        errors++;
        $display("FAIL b2b%0d got sum=%h cout=%b want sum=%h cout=%b", k, sum, cout, vs[k], vc[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    a = 8'h40; b = 8'h02; cin = 1'b1;
    step();
    checks++;
    if (sum !== 8'h43 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre got sum=%h cout=%b want sum=43 cout=0", sum, cout);
    end
    rst = 1'b1; a = 8'hF0; b = 8'h20; cin = 1'b1;
    step();
    checks++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cycle got sum=%h cout=%b want sum=00 cout=0", sum, cout);
    end
    rst = 1'b0; a = 8'h81; b = 8'h7E; cin = 1'b0;
    step();
    checks++;
    if (sum !== 8'hFF || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_resume got sum=%h cout=%b want sum=ff cout=0", sum, cout);
    end
    a = 8'hF0; b = 8'h20; cin = 1'b1;
    step();
    checks++;
    if (sum !== 8'h11 || cout !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after got sum=%h cout=%b want sum=11 cout=1", sum, cout);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_basic();
    test_carry_prop();
    test_cin_ripple();
    test_registered();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
